host_ft245_read_scheduler: RTL and testbench

Sequencer and arbiter for the host-side FT245 read model in the data-collector testbench. Two independent stimulus sources push bytes into private FIFOs. The block round-robins between them, one byte per FT245 read cycle. For each byte it pulses the model's start-read strobe, holds the byte stable, waits for read-cycle-complete, and reports completion, source, running count and timeout.

---
 rtl/host_ft245_read_scheduler.sv | 169 ++++++++++++++++
 tb/tb_host_ft245_read_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_ft245_read_scheduler.sv
// Round-robin read scheduler for the host-side FT245 model: two private byte FIFOs
// feed one read cycle at a time through a LAUNCH/WAIT/DONE handshake with timeout.
module host_ft245_read_scheduler #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_WR,
  input  logic [7:0]  REQ0_BYTE,
  output logic        REQ0_FULL,
  input  logic        REQ1_WR,
  input  logic [7:0]  REQ1_BYTE,
  output logic        REQ1_FULL,
  output logic        START_READ_CYCLE,
  output logic [7:0]  TRANSMIT_BYTE,
  input  logic        READ_CYCLE_COMPLETE,
  output logic        BUSY,
  output logic        GRANT,
  output logic        BYTE_DONE,
  output logic        DONE_SRC,
  output logic [15:0] BYTE_COUNT,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   occ_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam occ_t OCC_ONE  = occ_t'(1);
  localparam occ_t OCC_FULL = occ_t'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_LAUNCH = 4'b0010,
    S_WAIT   = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;
  logic        last_grant_q, grant_q;
  logic [7:0]  tx_q;

  logic [7:0]  mem_q    [2][DEPTH];
  ptr_t        wr_ptr_q [2];
  ptr_t        rd_ptr_q [2];
  occ_t        occ_q    [2];
  logic [7:0]  wdata    [2];
  logic [1:0]  wr, full, nempty, push, pop;
  logic        pick, launch;

  assign wr       = {REQ1_WR, REQ0_WR};
  assign wdata[0] = REQ0_BYTE;
  assign wdata[1] = REQ1_BYTE;

  // A write is judged against the registered full flag, so a same-cycle pop never rescues it.
  always_comb begin
    full   = '0;
    nempty = '0;
    push   = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      full[r]   = (occ_q[r] == OCC_FULL);
      nempty[r] = (occ_q[r] != '0);
      push[r]   = wr[r] & ~full[r];
    end
  end

  always_comb begin
    pick   = (nempty == 2'b11) ? ~last_grant_q : nempty[1];
    launch = (state_q == S_IDLE) && (nempty != 2'b00);
    pop    = '0;
    if (launch) pop = pick ? 2'b10 : 2'b01;
  end

  always_ff @(posedge CLK) begin
    for (int unsigned r = 0; r < 2; r++) begin
      if (push[r]) mem_q[r][wr_ptr_q[r]] <= wdata[r];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned r = 0; r < 2; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        occ_q[r]    <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < 2; r++) begin
        if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + PTR_ONE;
        if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + PTR_ONE;
        case ({push[r], pop[r]})
          2'b10:   occ_q[r] <= occ_q[r] + OCC_ONE;
          2'b01:   occ_q[r] <= occ_q[r] - OCC_ONE;
          default: occ_q[r] <= occ_q[r];
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE:   if (nempty != 2'b00) state_d = S_LAUNCH;
      S_LAUNCH: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      // Completion is checked first so it wins over a coincident timeout.
      S_WAIT: begin
        if (READ_CYCLE_COMPLETE) begin
          state_d = S_DONE;
        end else if (tcnt_q == TIMEOUT - 16'd1) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = count_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      tcnt_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      tx_q         <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (launch) begin
        last_grant_q <= pick;
        grant_q      <= pick;
        tx_q         <= mem_q[pick][rd_ptr_q[pick]];
      end
    end
  end

  assign REQ0_FULL        = full[0];
  assign REQ1_FULL        = full[1];
  assign START_READ_CYCLE = (state_q == S_LAUNCH);
  assign TRANSMIT_BYTE    = tx_q;
  assign BUSY             = (state_q != S_IDLE);
  assign GRANT            = grant_q;
  assign BYTE_DONE        = (state_q == S_DONE);
  assign DONE_SRC         = (state_q == S_DONE) & grant_q;
  assign BYTE_COUNT       = count_q;
  assign TIMEOUT_ERR      = err_q;

endmodule

// File: tb/tb_host_ft245_read_scheduler.sv
// Directed bench for host_ft245_read_scheduler: one instance at the default timeout,
// a second with TIMEOUT = 10 for the timeout and coincidence cases.
module tb_host_ft245_read_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr0 = 1'b0, wr1 = 1'b0, cmp = 1'b0;
  logic [7:0]  b0 = '0, b1 = '0;
  logic        full0, full1, start, busy, grant, bdone, dsrc, terr;
  logic [7:0]  tx;
  logic [15:0] bcount;

  logic        t_wr0 = 1'b0, t_cmp = 1'b0;
  logic [7:0]  t_b0 = '0;
  logic        t_full0, t_full1, t_start, t_busy, t_grant, t_bdone, t_dsrc, t_terr;
  logic [7:0]  t_tx;
  logic [15:0] t_bcount;

  int tests  = 0;
  int failed = 0;

  logic [7:0] q_byte[$];
  logic       q_grant[$];
  logic       q_src[$];
  int         strobe_cnt = 0;
  int         t_done_cnt = 0;

  always #5 clk = ~clk;

  host_ft245_read_scheduler #(.DEPTH_LOG2(3)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_WR(wr0), .REQ0_BYTE(b0), .REQ0_FULL(full0),
    .REQ1_WR(wr1), .REQ1_BYTE(b1), .REQ1_FULL(full1),
    .START_READ_CYCLE(start), .TRANSMIT_BYTE(tx), .READ_CYCLE_COMPLETE(cmp),
    .BUSY(busy), .GRANT(grant), .BYTE_DONE(bdone), .DONE_SRC(dsrc),
    .BYTE_COUNT(bcount), .TIMEOUT_ERR(terr)
  );

  host_ft245_read_scheduler #(.DEPTH_LOG2(3), .TIMEOUT(16'd10)) dut_t (
    .CLK(clk), .RST(rst),
    .REQ0_WR(t_wr0), .REQ0_BYTE(t_b0), .REQ0_FULL(t_full0),
    .REQ1_WR(1'b0), .REQ1_BYTE(8'h00), .REQ1_FULL(t_full1),
    .START_READ_CYCLE(t_start), .TRANSMIT_BYTE(t_tx), .READ_CYCLE_COMPLETE(t_cmp),
    .BUSY(t_busy), .GRANT(t_grant), .BYTE_DONE(t_bdone), .DONE_SRC(t_dsrc),
    .BYTE_COUNT(t_bcount), .TIMEOUT_ERR(t_terr)
  );

  always @(negedge clk) begin
    if (start) begin
      q_byte.push_back(tx);
      q_grant.push_back(grant);
      strobe_cnt++;
    end
    if (bdone) q_src.push_back(dsrc);
    if (t_bdone) t_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr0 = 1'b0; wr1 = 1'b0; cmp = 1'b0; t_wr0 = 1'b0; t_cmp = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q_byte.delete();
    q_grant.delete();
    q_src.delete();
    strobe_cnt = 0;
    t_done_cnt = 0;
  endtask

  task automatic push0(input logic [7:0] d);
    wr0 = 1'b1; b0 = d;
    tick();
    wr0 = 1'b0;
  endtask

  task automatic push2(input logic [7:0] d0, input logic [7:0] d1);
    wr0 = 1'b1; b0 = d0; wr1 = 1'b1; b1 = d1;
    tick();
    wr0 = 1'b0; wr1 = 1'b0;
  endtask

  // Waits (bounded) for the main instance to sit in WAIT, then completes after n cycles.
  task automatic serve(input int n);
    int i;
    i = 0;
    while (!(busy && !start && !bdone) && i < 50) begin
      tick();
      i++;
    end
    check("serve_wait_seen", {31'd0, busy && !start && !bdone}, 32'd1);
    repeat (n) tick();
    cmp = 1'b1;
    tick();
    cmp = 1'b0;
    check("serve_byte_done", {31'd0, bdone}, 32'd1);
    tick();
  endtask

  logic [7:0] rr_bytes [5];
  logic       rr_grants[5];

  initial begin
    rr_bytes  = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03};
    rr_grants = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("reset_outputs", {1'b0, start, tx, busy, grant, bdone, dsrc, bcount, terr, full0, full1}, 32'd0);
    check("reset_outputs_t", {1'b0, t_start, t_tx, t_busy, t_grant, t_bdone, t_dsrc, t_bcount, t_terr, t_full0, t_full1}, 32'd0);

    // Single byte
    wr0 = 1'b1; b0 = 8'hA5;
    tick();
    wr0 = 1'b0;
    check("single_no_early_strobe", {31'd0, start}, 32'd0);
    tick();
    check("single_strobe", {31'd0, start}, 32'd1);
    check("single_tx", {24'd0, tx}, 32'hA5);
    check("single_grant", {31'd0, grant}, 32'd0);
    tick();
    check("single_strobe_one_cycle", {31'd0, start}, 32'd0);
    check("single_busy_wait", {31'd0, busy}, 32'd1);
    repeat (19) tick();
    cmp = 1'b1;
    tick();
    cmp = 1'b0;
    check("single_byte_done", {31'd0, bdone}, 32'd1);
    check("single_done_src", {31'd0, dsrc}, 32'd0);
    check("single_count_before", {16'd0, bcount}, 32'd0);
    tick();
    check("single_done_pulse_end", {31'd0, bdone}, 32'd0);
    check("single_count", {16'd0, bcount}, 32'd1);
    check("single_idle", {31'd0, busy}, 32'd0);

    // Round-robin
    do_reset();
    push2(8'h01, 8'h11);
    push2(8'h02, 8'h12);
    push0(8'h03);
    for (int k = 0; k < 5; k++) serve(2);
    check("rr_n_bytes", q_byte.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < q_byte.size()) begin
        check($sformatf("rr_byte%0d", k), {24'd0, q_byte[k]}, {24'd0, rr_bytes[k]});
        check($sformatf("rr_grant%0d", k), {31'd0, q_grant[k]}, {31'd0, rr_grants[k]});
      end
      if (k < q_src.size())
        check($sformatf("rr_src%0d", k), {31'd0, q_src[k]}, {31'd0, rr_grants[k]});
    end
    check("rr_count", {16'd0, bcount}, 32'd5);

    // Full FIFO while stalled in WAIT
    do_reset();
    push0(8'hF0);
    for (int k = 0; k < 9; k++) begin
      push0(8'h80 + 8'(k));
      check($sformatf("full_after_write%0d", k), {31'd0, full0}, (k >= 7) ? 32'd1 : 32'd0);
    end
    check("full_other_fifo", {31'd0, full1}, 32'd0);
    for (int k = 0; k < 9; k++) serve(1);
    tick();
    tick();
    check("full_drain_count", q_byte.size(), 32'd9);
    if (q_byte.size() > 0) check("full_first", {24'd0, q_byte[0]}, 32'hF0);
    for (int k = 1; k < 9; k++)
      if (k < q_byte.size())
        check($sformatf("full_drain%0d", k), {24'd0, q_byte[k]}, 32'h80 + 32'(k - 1));
    check("full_cleared", {31'd0, full0}, 32'd0);
    check("full_no_extra_strobe", strobe_cnt, 32'd9);

    // Timeout (TIMEOUT = 10)
    do_reset();
    t_wr0 = 1'b1; t_b0 = 8'h33;
    tick();
    t_wr0 = 1'b0;
    tick();
    check("to_strobe", {31'd0, t_start}, 32'd1);
    tick();
    repeat (9) tick();
    check("to_still_wait", {31'd0, t_busy}, 32'd1);
    check("to_err_not_yet", {31'd0, t_terr}, 32'd0);
    tick();
    check("to_back_idle", {31'd0, t_busy}, 32'd0);
    check("to_err_set", {31'd0, t_terr}, 32'd1);
    check("to_count_unchanged", {16'd0, t_bcount}, 32'd0);
    check("to_no_byte_done", t_done_cnt, 32'd0);
    t_wr0 = 1'b1; t_b0 = 8'h44;
    tick();
    t_wr0 = 1'b0;
    tick();
    check("to_next_strobe", {31'd0, t_start}, 32'd1);
    check("to_next_tx", {24'd0, t_tx}, 32'h44);
    tick();
    tick();
    t_cmp = 1'b1;
    tick();
    t_cmp = 1'b0;
    check("to_next_done", {31'd0, t_bdone}, 32'd1);
    tick();
    check("to_next_count", {16'd0, t_bcount}, 32'd1);
    check("to_err_sticky", {31'd0, t_terr}, 32'd1);

    // Completion coincident with the last WAIT cycle
    do_reset();
    t_wr0 = 1'b1; t_b0 = 8'h55;
    tick();
    t_wr0 = 1'b0;
    tick();
    tick();
    repeat (9) tick();
    t_cmp = 1'b1;
    tick();
    t_cmp = 1'b0;
    check("coin_done", {31'd0, t_bdone}, 32'd1);
    check("coin_no_err", {31'd0, t_terr}, 32'd0);
    tick();
    check("coin_count", {16'd0, t_bcount}, 32'd1);
    check("coin_err_stays0", {31'd0, t_terr}, 32'd0);

    // Reset mid-WAIT with bytes still queued
    do_reset();
    push0(8'hC1);
    push0(8'hC2);
    push0(8'hC3);
    wr1 = 1'b1; b1 = 8'hD1;
    tick();
    wr1 = 1'b0;
    tick();
    check("rst_mid_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", {1'b0, start, tx, busy, grant, bdone, dsrc, bcount, terr, full0, full1}, 32'd0);
    rst = 1'b0;
    strobe_cnt = 0;
    repeat (20) tick();
    check("rst_mid_no_strobe", strobe_cnt, 32'd0);
    check("rst_mid_idle", {31'd0, busy}, 32'd0);
    push0(8'hE7);
    tick();
    check("rst_mid_new_strobe", {31'd0, start}, 32'd1);
    check("rst_mid_new_tx", {24'd0, tx}, 32'hE7);
    check("rst_mid_new_grant", {31'd0, grant}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
